// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  // Instruction presented to decode while the queue is empty.
  localparam logic [INST_W-1:0] NOP     = 32'h0000_0000;
  localparam logic [PC_W-1:0]   PC_STEP = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fq_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fq_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular storage for fetched {instruction, pc+4} entries.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fq_entry_t                head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fq_entry_t      mem_r [DEPTH];
  logic [AW-1:0]  head_r;
  logic [AW-1:0]  tail_r;
  logic [AW:0]    count_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Never write past full or read below empty, whatever the caller asks.
  always_comb begin
    do_push_s = push && (count_r != FULL) && !clr;
    do_pop_s  = pop && (count_r != {(AW+1){1'b0}}) && !clr;
  end

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else if (clr) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) tail_r <= tail_r + AW'(1);
      if (do_pop_s)  head_r <= head_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[tail_r] <= push_data;
  end

  assign count     = count_r;
  assign head_data = mem_r[head_r];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one request at a time to instruction
// memory and buffers returned words for the decode stage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_inst,
  output logic [31:0] fq_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_state_e      state_r;
  logic [31:0]    pc_r;
  logic           imem_req_r;
  logic [CW-1:0]  count_s;
  logic [CW-1:0]  post_count_s;
  logic           push_s;
  logic           pop_s;
  logic           fq_valid_s;
  fq_entry_t      push_entry_s;
  fq_entry_t      head_s;

  // Queue handshakes; a redirect suppresses both push and pop.
  always_comb begin
    fq_valid_s        = (count_s != {CW{1'b0}});
    push_s            = (state_r == ST_WAIT) && imem_rvalid && !redirect;
    pop_s             = fq_valid_s && fq_ready && !redirect;
    push_entry_s.inst = imem_rdata;
    push_entry_s.pc   = next_pc(pc_r);
    if (push_s && !pop_s) begin
      post_count_s = count_s + CW'(1);
    end else if (!push_s && pop_s) begin
      post_count_s = count_s - CW'(1);
    end else begin
      post_count_s = count_s;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .count     (count_s),
    .head_data (head_s)
  );

  // Request sequencer: at most one request outstanding, and a new one only
  // when the returning word is guaranteed a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      imem_req_r <= 1'b0;
    end else if (redirect) begin
      pc_r       <= redirect_pc;
      imem_req_r <= 1'b0;
      case (state_r)
        // A request still in flight must have its response swallowed.
        ST_WAIT: state_r <= imem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_r <= imem_rvalid ? ST_IDLE : ST_DROP;
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_s < FULL) begin
            imem_req_r <= 1'b1;
            state_r    <= ST_WAIT;
          end else begin
            imem_req_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            pc_r <= next_pc(pc_r);
            if (post_count_s < FULL) begin
              imem_req_r <= 1'b1;
            end else begin
              imem_req_r <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else begin
            imem_req_r <= 1'b0;
          end
        end
        ST_DROP: begin
          imem_req_r <= 1'b0;
          if (imem_rvalid) state_r <= ST_IDLE;
        end
        default: begin
          imem_req_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign fq_valid  = fq_valid_s;
  assign fq_inst   = fq_valid_s ? head_s.inst : NOP;
  assign fq_pc     = fq_valid_s ? head_s.pc   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table, directed
// corner sequences and a randomized run against a queue-level model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fq_valid;
  logic        fq_ready = 1'b0;
  logic [31:0] fq_inst;
  logic [31:0] fq_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .fq_valid(fq_valid), .fq_ready(fq_ready),
    .fq_inst(fq_inst), .fq_pc(fq_pc)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue, next fetch address, one outstanding flag
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        q_m[$];
  logic [31:0] pc_m;
  bit          req_m, out_m, drop_m;

  // Memory model: one pending request with a latency countdown
  bit          pend_v;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat_cfg;
  bit          force_en;
  logic [31:0] force_data;

  typedef struct {
    bit redir; logic [31:0] rpc; bit rv; logic [31:0] rd; bit rdy;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_inst; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit          ev;
    logic [31:0] ei, ep;
    ev = (q_m.size() != 0);
    ei = ev ? q_m[0].inst : 32'h0;
    ep = ev ? q_m[0].pc   : 32'h0;
    check32($sformatf("%s.imem_req", tag),  {31'b0, imem_req}, {31'b0, req_m});
    check32($sformatf("%s.imem_addr", tag), imem_addr, pc_m);
    check32($sformatf("%s.fq_valid", tag),  {31'b0, fq_valid}, {31'b0, ev});
    check32($sformatf("%s.fq_inst", tag),   fq_inst, ei);
    check32($sformatf("%s.fq_pc", tag),     fq_pc, ep);
  endtask

  task automatic model_update(input bit redir, input logic [31:0] rpc, input bit rdy,
                              input bit rv, input logic [31:0] rd);
    int pre;
    req_m = 1'b0;
    if (redir) begin
      q_m.delete();
      pc_m = rpc;
      if (out_m && rv) begin
        out_m = 1'b0; drop_m = 1'b0;
      end else if (out_m) begin
        drop_m = 1'b1;
      end
    end else begin
      pre = q_m.size();
      if (pre > 0 && rdy) void'(q_m.pop_front());
      if (out_m && rv) begin
        out_m = 1'b0;
        if (drop_m) begin
          drop_m = 1'b0;
        end else begin
          q_m.push_back('{rd, pc_m + 32'd4});
          pc_m = pc_m + 32'd4;
          if (q_m.size() < DEPTH) begin req_m = 1'b1; out_m = 1'b1; end
        end
      end else if (!out_m && pre < DEPTH) begin
        req_m = 1'b1; out_m = 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, update models at posedge, compare at negedge
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          rv, req_seen;
    logic [31:0] rd, addr_seen;
    rv = pend_v && (pend_cnt == 0);
    rd = force_en ? force_data : mem_word(pend_addr);
    redirect = redir; redirect_pc = rpc; fq_ready = rdy;
    imem_rvalid = rv; imem_rdata = rv ? rd : 32'h0;
    req_seen = imem_req; addr_seen = imem_addr;
    @(posedge clk);
    model_update(redir, rpc, rdy, rv, rd);
    if (rv) pend_v = 1'b0;
    else if (pend_v && pend_cnt > 0) pend_cnt--;
    if (req_seen) begin
      pend_v = 1'b1; pend_addr = addr_seen;
      pend_cnt = (lat_cfg == 0) ? int'($urandom_range(2, 0)) : lat_cfg - 1;
    end
    @(negedge clk);
    check_model("step");
  endtask

  task automatic do_reset(input bit keep_pend);
    redirect = 1'b0; fq_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check32("rst.imem_req", {31'b0, imem_req}, 32'h0);
    check32("rst.imem_addr", imem_addr, RESET_PC);
    check32("rst.fq_valid", {31'b0, fq_valid}, 32'h0);
    check32("rst.fq_inst", fq_inst, 32'h0);
    check32("rst.fq_pc", fq_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_m.delete(); pc_m = RESET_PC; req_m = 1'b0; out_m = 1'b0; drop_m = 1'b0;
    if (!keep_pend) pend_v = 1'b0;
    force_en = 1'b0;
  endtask

  initial begin
    int reqs;
    bit hit;
    pend_v = 1'b0; pend_cnt = 0; pend_addr = 32'h0; lat_cfg = 1;
    force_en = 1'b0; force_data = 32'h0;

    // Directed table: 1-cycle memory, consumer always ready, then a redirect
    tbl[0]  = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h0,  1'b1, 32'h1111_0000, 1'b1, 1'b1, 32'h4,  1'b1, 32'h1111_0000, 32'h4};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h4,  1'b0, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 32'h2222_0004, 1'b1, 1'b1, 32'h8,  1'b1, 32'h2222_0004, 32'h8};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h8,  1'b0, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 32'h3333_0008, 1'b1, 1'b1, 32'hC,  1'b1, 32'h3333_0008, 32'hC};
    tbl[7]  = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b0, 32'hC,  1'b0, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 1'b0, 32'h40, 1'b0, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 32'h0000_DEAD, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b1, 32'h40, 1'b0, 32'h0,         32'h0};

    do_reset(1'b0);
    for (int i = 0; i < 11; i++) begin
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; fq_ready = tbl[i].rdy;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
      check32($sformatf("tbl%0d.imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      check32($sformatf("tbl%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
      check32($sformatf("tbl%0d.fq_valid", i), {31'b0, fq_valid}, {31'b0, tbl[i].e_valid});
      check32($sformatf("tbl%0d.fq_inst", i), fq_inst, tbl[i].e_inst);
      check32($sformatf("tbl%0d.fq_pc", i), fq_pc, tbl[i].e_pc);
    end

    // Back-pressure: queue fills to DEPTH, then a single pop frees one slot
    do_reset(1'b0);
    lat_cfg = 1;
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b0);
    check32("full.imem_req", {31'b0, imem_req}, 32'h0);
    check32("full.fq_valid", {31'b0, fq_valid}, 32'h1);
    check32("full.fq_inst", fq_inst, mem_word(RESET_PC));
    step(1'b0, 32'h0, 1'b1);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (imem_req) reqs++;
    end
    check32("full.one_request", reqs, 32'd1);

    // Streaming with the consumer always ready: pointers wrap, order kept
    for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect while a request is in flight; the late response is dropped
    do_reset(1'b0);
    lat_cfg = 3; force_en = 1'b1; force_data = 32'h0000_DEAD;
    step(1'b0, 32'h0, 1'b1);
    check32("drop.req_before", {31'b0, imem_req}, 32'h1);
    step(1'b1, 32'h0000_0100, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(1'b0, 32'h0, 1'b1);
      hit = imem_req;
    end
    force_en = 1'b0;
    check32("drop.refetch_seen", {31'b0, hit}, 32'h1);
    check32("drop.refetch_addr", imem_addr, 32'h0000_0100);
    check32("drop.queue_empty", {31'b0, fq_valid}, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect coincident with a response and a pop at count 2
    do_reset(1'b0);
    lat_cfg = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (q_m.size() == 2 && pend_v && pend_cnt == 0) hit = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    check32("coinc.setup_reached", {31'b0, hit}, 32'h1);
    step(1'b1, 32'h0000_2000, 1'b1);
    check32("coinc.fq_valid", {31'b0, fq_valid}, 32'h0);
    check32("coinc.pc", imem_addr, 32'h0000_2000);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // PC wraps past the top of the address space
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0);
    check32("wrap.head_pc", fq_pc, 32'hFFFF_FFFC);

    // Reset in the middle of WAIT; the stale response lands in IDLE
    do_reset(1'b0);
    lat_cfg = 3;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, 32'h0, 1'b0);
      hit = pend_v && (pend_cnt > 0) && (q_m.size() > 0);
    end
    check32("midrst.setup_reached", {31'b0, hit}, 32'h1);
    do_reset(1'b1);
    pend_cnt = 0;
    step(1'b0, 32'h0, 1'b1);
    check32("midrst.addr", imem_addr, RESET_PC);
    check32("midrst.req", {31'b0, imem_req}, 32'h1);
    check32("midrst.no_push", {31'b0, fq_valid}, 32'h0);
    lat_cfg = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    check32("midrst.first_word", fq_inst, mem_word(RESET_PC));

    // Randomized traffic against the model
    lat_cfg = 0;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(11, 0) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(2, 0) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc  in  32  target address, valid with redirect.
REQ-007 SHALL have port imem_req  out  1  single-cycle fetch request.
REQ-008 SHALL have port imem_addr  out  32  fetch address; stable from request until response.
REQ-009 SHALL have port imem_rvalid  in  1  response strobe, >=1 cycle after imem_req.
REQ-010 SHALL have port imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-011 SHALL have port fq_valid  out  1  queue head holds an instruction.
REQ-012 SHALL have port fq_ready  in  1  IF/ID register write enable (consumer accepts).
REQ-013 SHALL have port fq_inst  out  32  head instruction; 32'h0 (NOP) when fq_valid=0.
REQ-014 SHALL have port fq_pc  out  32  head fetch address + 4; 32'h0 when fq_valid=0.

Function
REQ-015 SHALL hold PC register; imem_addr = PC.
REQ-016 SHALL implement FSM IDLE, WAIT, DROP.
REQ-017 IDLE: if count<DEPTH and no redirect, SHALL pulse imem_req one cycle and enter WAIT.
REQ-018 WAIT, imem_rvalid, no redirect: SHALL push {imem_rdata, PC+4} at tail, PC<=PC+4; if post-push/pop count<DEPTH, SHALL issue next request same cycle (stay WAIT), else IDLE.
REQ-019 WAIT, redirect, no imem_rvalid: SHALL enter DROP.
REQ-020 DROP: SHALL discard next imem_rvalid and enter IDLE; no push.
REQ-021 Redirect in any state SHALL clear queue (count<=0), set PC<=redirect_pc, take priority over push and pop same cycle.
REQ-022 Redirect in WAIT coincident with imem_rvalid SHALL discard data and enter IDLE.
REQ-023 Pop SHALL occur when fq_valid && fq_ready && !redirect; head advances one entry.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, preserve order.
REQ-025 Request SHALL never issue when count + outstanding would exceed DEPTH; push never overflows.
REQ-026 fq_valid SHALL equal (count!=0); fq_inst/fq_pc driven from head storage, no input-to-output combinational path.
REQ-027 Head/tail pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-028 PC arithmetic SHALL be 32-bit modulo 2^32 (wrap at 32'hFFFFFFFC -> 0).
REQ-029 Minimum latency: imem_rvalid to fq_valid SHALL be one cycle (entry visible cycle after push).

Reset
REQ-030 On rst SHALL immediately set PC=RESET_PC, count=0, pointers=0, state=IDLE, imem_req=0, fq_valid=0, fq_inst=0, fq_pc=0.
REQ-031 First imem_req SHALL occur in first clock cycle after rst deasserts.
REQ-032 Reset mid-WAIT SHALL abandon outstanding request; a late imem_rvalid in IDLE SHALL be ignored.

Structure
REQ-033 Shared package SHALL hold FSM state enum, NOP constant 32'h0, instruction width 32.
REQ-034 Storage SHALL be sub-module fetch_fifo (synchronous push/pop/clear, count, head read).

Verification
REQ-035 Reset, 1-cycle memory, fq_ready=1: words at 0,4,8 -> fq_inst in order, fq_pc 4,8,12.
REQ-036 fq_ready=0, DEPTH=4: after 4 pushes imem_req stays 0, count=4; fq_ready=1 one cycle -> one request issues.
REQ-037 Redirect to 32'h100 while WAIT, rvalid 2 cycles later with 32'hDEAD -> data dropped, next imem_addr=32'h100, queue empty.
REQ-038 Redirect same cycle as imem_rvalid and pop with count=2 -> count=0, fq_valid=0 next cycle, PC=redirect_pc.
REQ-039 Full queue, simultaneous push and pop -> count stays 4, order preserved through pointer wrap.
REQ-040 rst asserted mid-WAIT -> outputs zero asynchronously; after release imem_addr=RESET_PC, stale rvalid ignored.
